id_stage: RTL

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// Instruction decode stage: field extraction, 32x32 register file with writeback
// bypass, branch resolution, and the ID/EXE pipeline register.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        valid_in,
  input  logic [31:0] instruction_in,
  input  logic [31:0] pc_in,
  input  logic        wb_en,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_value,
  output logic [3:0]  exe_cmd,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic        wb_en_out,
  output logic [4:0]  dest,
  output logic [4:0]  src1,
  output logic [4:0]  src2,
  output logic [31:0] val1,
  output logic [31:0] val2,
  output logic [31:0] st_val,
  output logic [31:0] pc_out,
  output logic        branch_taken,
  output logic [31:0] branch_address,
  output logic        two_src
);

  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000011;
  localparam logic [5:0] OP_AND  = 6'b000101;
  localparam logic [5:0] OP_OR   = 6'b000110;
  localparam logic [5:0] OP_NOR  = 6'b000111;
  localparam logic [5:0] OP_XOR  = 6'b001000;
  localparam logic [5:0] OP_SLA  = 6'b001001;
  localparam logic [5:0] OP_SLL  = 6'b001010;
  localparam logic [5:0] OP_SRA  = 6'b001011;
  localparam logic [5:0] OP_SRL  = 6'b001100;
  localparam logic [5:0] OP_ADDI = 6'b100000;
  localparam logic [5:0] OP_SUBI = 6'b100001;
  localparam logic [5:0] OP_LD   = 6'b100100;
  localparam logic [5:0] OP_ST   = 6'b100101;
  localparam logic [5:0] OP_BEZ  = 6'b101000;
  localparam logic [5:0] OP_BNE  = 6'b101001;
  localparam logic [5:0] OP_JMP  = 6'b101010;

  localparam logic [3:0] CMD_NOP = 4'b1111;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;

  assign opcode   = instruction_in[31:26];
  assign rs       = instruction_in[25:21];
  assign rt       = instruction_in[20:16];
  assign rd       = instruction_in[15:11];
  assign imm_sext = {{16{instruction_in[15]}}, instruction_in[15:0]};

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  // regs_d is the post-write view, so reading it gives the same-cycle bypass;
  // R0 is never written and resets to 0, so it always reads 0.
  always_comb begin
    regs_d = regs_q;
    if (wb_en && (wb_dest != 5'd0)) begin
      regs_d[wb_dest] = wb_value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  logic [31:0] rs_val, rt_val;
  assign rs_val = regs_d[rs];
  assign rt_val = regs_d[rt];

  logic [3:0]  dec_cmd;
  logic        dec_mem_r, dec_mem_w, dec_wb;
  logic [4:0]  dec_dest, dec_src1, dec_src2;
  logic [31:0] dec_val1, dec_val2, dec_st_val;
  logic        dec_two_src, is_bez, is_bne, is_jmp;

  always_comb begin
    dec_cmd     = CMD_NOP;
    dec_mem_r   = 1'b0;
    dec_mem_w   = 1'b0;
    dec_wb      = 1'b0;
    dec_dest    = '0;
    dec_src1    = '0;
    dec_src2    = '0;
    dec_val1    = '0;
    dec_val2    = '0;
    dec_st_val  = '0;
    dec_two_src = 1'b0;
    is_bez      = 1'b0;
    is_bne      = 1'b0;
    is_jmp      = 1'b0;
    unique case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR,
      OP_SLA, OP_SLL, OP_SRA, OP_SRL: begin
        dec_wb      = 1'b1;
        dec_dest    = rd;
        dec_src1    = rs;
        dec_src2    = rt;
        dec_val1    = rs_val;
        dec_val2    = rt_val;
        dec_two_src = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_LD: begin
        dec_wb    = 1'b1;
        dec_dest  = rt;
        dec_src1  = rs;
        dec_val1  = rs_val;
        dec_val2  = imm_sext;
        dec_mem_r = (opcode == OP_LD);
      end
      OP_ST: begin
        dec_mem_w   = 1'b1;
        dec_src1    = rs;
        dec_src2    = rt;
        dec_val1    = rs_val;
        dec_val2    = imm_sext;
        dec_st_val  = rt_val;
        dec_two_src = 1'b1;
      end
      OP_BEZ: begin
        dec_src1 = rs;
        is_bez   = 1'b1;
      end
      OP_BNE: begin
        dec_src1    = rs;
        dec_src2    = rt;
        dec_two_src = 1'b1;
        is_bne      = 1'b1;
      end
      OP_JMP:  is_jmp = 1'b1;
      default: ;
    endcase

    unique case (opcode)
      OP_ADD, OP_ADDI, OP_LD, OP_ST: dec_cmd = 4'b0000;
      OP_SUB, OP_SUBI:               dec_cmd = 4'b0010;
      OP_AND:                        dec_cmd = 4'b0100;
      OP_OR:                         dec_cmd = 4'b0101;
      OP_NOR:                        dec_cmd = 4'b0110;
      OP_XOR:                        dec_cmd = 4'b0111;
      OP_SLA, OP_SLL:                dec_cmd = 4'b1000;
      OP_SRA:                        dec_cmd = 4'b1001;
      OP_SRL:                        dec_cmd = 4'b1010;
      default:                       dec_cmd = CMD_NOP;
    endcase
  end

  assign two_src        = dec_two_src;
  assign branch_address = pc_in + 32'd4 + {imm_sext[29:0], 2'b00};
  assign branch_taken   = !rst && valid_in && !stall &&
                          ((is_bez && (rs_val == 32'd0)) ||
                           (is_bne && (rs_val != rt_val)) ||
                           is_jmp);

  logic [3:0]  exe_cmd_q, exe_cmd_d;
  logic        mem_r_en_q, mem_r_en_d, mem_w_en_q, mem_w_en_d, wb_en_out_q, wb_en_out_d;
  logic [4:0]  dest_q, dest_d, src1_q, src1_d, src2_q, src2_d;
  logic [31:0] val1_q, val1_d, val2_q, val2_d, st_val_q, st_val_d, pc_out_q, pc_out_d;

  // Anything not issuing this cycle becomes a bubble.
  always_comb begin
    exe_cmd_d   = CMD_NOP;
    mem_r_en_d  = 1'b0;
    mem_w_en_d  = 1'b0;
    wb_en_out_d = 1'b0;
    dest_d      = '0;
    src1_d      = '0;
    src2_d      = '0;
    val1_d      = '0;
    val2_d      = '0;
    st_val_d    = '0;
    pc_out_d    = '0;
    if (valid_in && !stall) begin
      exe_cmd_d   = dec_cmd;
      mem_r_en_d  = dec_mem_r;
      mem_w_en_d  = dec_mem_w;
      wb_en_out_d = dec_wb;
      dest_d      = dec_dest;
      src1_d      = dec_src1;
      src2_d      = dec_src2;
      val1_d      = dec_val1;
      val2_d      = dec_val2;
      st_val_d    = dec_st_val;
      pc_out_d    = pc_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_cmd_q   <= CMD_NOP;
      mem_r_en_q  <= 1'b0;
      mem_w_en_q  <= 1'b0;
      wb_en_out_q <= 1'b0;
      dest_q      <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      val1_q      <= '0;
      val2_q      <= '0;
      st_val_q    <= '0;
      pc_out_q    <= '0;
    end else begin
      exe_cmd_q   <= exe_cmd_d;
      mem_r_en_q  <= mem_r_en_d;
      mem_w_en_q  <= mem_w_en_d;
      wb_en_out_q <= wb_en_out_d;
      dest_q      <= dest_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      val1_q      <= val1_d;
      val2_q      <= val2_d;
      st_val_q    <= st_val_d;
      pc_out_q    <= pc_out_d;
    end
  end

  assign exe_cmd   = exe_cmd_q;
  assign mem_r_en  = mem_r_en_q;
  assign mem_w_en  = mem_w_en_q;
  assign wb_en_out = wb_en_out_q;
  assign dest      = dest_q;
  assign src1      = src1_q;
  assign src2      = src2_q;
  assign val1      = val1_q;
  assign val2      = val2_q;
  assign st_val    = st_val_q;
  assign pc_out    = pc_out_q;

endmodule
